// File: rtl/fc_stream_engine.sv
// -----------------------------------------------------------------------------
// fc_stream_engine
//   Streaming fully-connected classifier head. Input elements x[j] arrive one
//   per valid/ready handshake. Every handshake updates OUT_LEN signed MAC
//   accumulators in parallel. At frame end the engine streams OUT_LEN results
//   out over a valid/ready interface. Each result is the accumulator shifted
//   down by FRAC_BITS, optionally ReLU'd, and saturated to DATA_W bits.
//   Weights and biases live in internal storage. They are written through
//   simple strobe ports while the engine is idle.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   w_wr_en/addr/data     weight write, addr = j*OUT_LEN + i
//   b_wr_en/addr/data     bias write, addr = neuron index i
//   in_valid/ready/data   input element stream
//   in_last               marks the final element of a frame
//   out_valid/ready/data  result stream, y[0] .. y[OUT_LEN-1]
//   out_last              high together with y[OUT_LEN-1]
//   busy                  frame in progress (accumulating or emitting)
//   err_len               one-cycle pulse when in_last disagrees with the count
// -----------------------------------------------------------------------------
module fc_stream_engine #(
   parameter int DATA_W    = 16,
   parameter int ACC_W     = 40,
   parameter int IN_LEN    = 120,
   parameter int OUT_LEN   = 10,
   parameter int FRAC_BITS = 8,
   parameter int RELU_EN   = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               w_wr_en,
   input  logic [$clog2(IN_LEN*OUT_LEN)-1:0]  w_wr_addr,
   input  logic [DATA_W-1:0]                  w_wr_data,
   input  logic                               b_wr_en,
   input  logic [$clog2(OUT_LEN)-1:0]         b_wr_addr,
   input  logic [DATA_W-1:0]                  b_wr_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [DATA_W-1:0]                  in_data,
   input  logic                               in_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_W-1:0]                  out_data,
   output logic                               out_last,
   output logic                               busy,
   output logic                               err_len
);

   localparam int WA_W = $clog2(IN_LEN*OUT_LEN);
   localparam int BA_W = $clog2(OUT_LEN);
   localparam int JW   = $clog2(IN_LEN);

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0]       OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0]       OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t                    state_r;
   state_t                    state_s;
   logic [JW-1:0]             j_r;
   logic [WA_W-1:0]           base_r;      // j_r*OUT_LEN, kept incrementally to avoid a multiplier
   logic [BA_W-1:0]           out_idx_r;
   logic                      err_r;

   logic signed [DATA_W-1:0]  w_mem_r [IN_LEN*OUT_LEN];
   logic signed [DATA_W-1:0]  b_mem_r [OUT_LEN];
   logic signed [ACC_W-1:0]   acc_view_s [OUT_LEN];

   logic                      in_hs_s;
   logic                      out_hs_s;
   logic                      j_at_end_s;
   logic                      frame_end_s;
   logic                      len_bad_s;
   logic                      out_at_end_s;
   logic [31:0]               w_addr_ext_s;
   logic [31:0]               b_addr_ext_s;
   logic signed [2*DATA_W-1:0] x_ext_s;

   // Fixed-point post-processing: floor shift, optional ReLU, saturation.
   function automatic logic [DATA_W-1:0] post_fn(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] r;
      r = a >>> FRAC_BITS;
      if ((RELU_EN != 0) && r[ACC_W-1]) begin
         r = '0;
      end else begin
         r = r;
      end
      if (r > SAT_MAX) begin
         post_fn = OUT_MAX;
      end else if (r < SAT_MIN) begin
         post_fn = OUT_MIN;
      end else begin
         post_fn = r[DATA_W-1:0];
      end
   endfunction

   assign in_hs_s      = in_valid && in_ready;
   assign out_hs_s     = out_valid && out_ready;
   assign j_at_end_s   = (j_r == JW'(IN_LEN-1));
   assign frame_end_s  = in_hs_s && (in_last || j_at_end_s);
   // A frame is well formed only when in_last coincides with the final element.
   assign len_bad_s    = in_hs_s && (in_last != j_at_end_s);
   assign out_at_end_s = (out_idx_r == BA_W'(OUT_LEN-1));
   assign w_addr_ext_s = 32'(w_wr_addr);
   assign b_addr_ext_s = 32'(b_wr_addr);
   assign x_ext_s      = {{DATA_W{in_data[DATA_W-1]}}, in_data};

   assign in_ready  = (state_r != S_OUTPUT) && !reset;
   assign out_valid = (state_r == S_OUTPUT);
   assign out_last  = (state_r == S_OUTPUT) && out_at_end_s;
   assign busy      = (state_r != S_IDLE);
   assign err_len   = err_r;
   assign out_data  = post_fn(acc_view_s[out_idx_r]);

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE, S_ACCUM: begin
            if (frame_end_s) begin
               state_s = S_OUTPUT;
            end else if (in_hs_s) begin
               state_s = S_ACCUM;
            end else begin
               state_s = state_r;
            end
         end
         S_OUTPUT: begin
            if (out_hs_s && out_at_end_s) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_OUTPUT;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State, element counter, output index and length-error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= S_IDLE;
         j_r       <= '0;
         base_r    <= '0;
         out_idx_r <= '0;
         err_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         err_r   <= len_bad_s;
         if (frame_end_s) begin
            j_r    <= '0;
            base_r <= '0;
         end else if (in_hs_s) begin
            j_r    <= j_r + JW'(1);
            base_r <= base_r + WA_W'(OUT_LEN);
         end else begin
            j_r    <= j_r;
            base_r <= base_r;
         end
         if (out_hs_s) begin
            out_idx_r <= out_at_end_s ? '0 : out_idx_r + BA_W'(1);
         end else begin
            out_idx_r <= out_idx_r;
         end
      end
   end

   // Weight and bias storage; writes are dropped while a frame is in flight.
   always_ff @(posedge clk) begin
      if (w_wr_en && !busy && (w_addr_ext_s < 32'(IN_LEN*OUT_LEN))) begin
         w_mem_r[w_wr_addr] <= w_wr_data;
      end
      if (b_wr_en && !busy && (b_addr_ext_s < 32'(OUT_LEN))) begin
         b_mem_r[b_wr_addr] <= b_wr_data;
      end
   end

   for (genvar g = 0; g < OUT_LEN; g++) begin : g_neuron
      logic [WA_W-1:0]            w_idx_s;
      logic signed [2*DATA_W-1:0] w_ext_s;
      logic signed [2*DATA_W-1:0] prod_s;
      logic signed [ACC_W-1:0]    prod_ext_s;
      logic signed [ACC_W-1:0]    bias_ext_s;
      logic signed [ACC_W-1:0]    acc_r;

      assign w_idx_s    = base_r + WA_W'(g);
      assign w_ext_s    = {{DATA_W{w_mem_r[w_idx_s][DATA_W-1]}}, w_mem_r[w_idx_s]};
      assign prod_s     = x_ext_s * w_ext_s;
      assign prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
      assign bias_ext_s = {{(ACC_W-DATA_W){b_mem_r[g][DATA_W-1]}}, b_mem_r[g]} <<< FRAC_BITS;
      assign acc_view_s[g] = acc_r;

      // Accumulator: the first element of a frame reloads from the bias.
      always_ff @(posedge clk) begin
         if (reset) begin
            acc_r <= '0;
         end else if (in_hs_s && (state_r == S_IDLE)) begin
            acc_r <= bias_ext_s + prod_ext_s;
         end else if (in_hs_s) begin
            acc_r <= acc_r + prod_ext_s;
         end else begin
            acc_r <= acc_r;
         end
      end
   end

endmodule

// File: tb/tb_fc_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_fc_stream_engine
//   Directed bench for fc_stream_engine with IN_LEN=4 and OUT_LEN=2. Three
//   instances share one stimulus stream:
//     d0: FRAC_BITS=0, RELU_EN=0
//     d1: FRAC_BITS=0, RELU_EN=1
//     d2: FRAC_BITS=8, RELU_EN=0
//   Expected results are hand-computed. The handshake timing of d0 is checked.
//   The result data of all three instances is checked.
// -----------------------------------------------------------------------------
module tb_fc_stream_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_wr_en;
   logic [2:0]  w_wr_addr;
   logic [15:0] w_wr_data;
   logic        b_wr_en;
   logic [0:0]  b_wr_addr;
   logic [15:0] b_wr_data;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_ready;

   logic        rdy [3];
   logic        ov  [3];
   logic [15:0] od  [3];
   logic        ol  [3];
   logic        bz  [3];
   logic        er  [3];

   int total_cnt = 0;
   int bad_cnt   = 0;

   always #5 clk = ~clk;

   fc_stream_engine #(.DATA_W(16), .ACC_W(40), .IN_LEN(4), .OUT_LEN(2), .FRAC_BITS(0), .RELU_EN(0)) d0 (
      .clk(clk), .reset(reset),
      .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
      .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
      .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data), .in_last(in_last),
      .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]),
      .busy(bz[0]), .err_len(er[0]));

   fc_stream_engine #(.DATA_W(16), .ACC_W(40), .IN_LEN(4), .OUT_LEN(2), .FRAC_BITS(0), .RELU_EN(1)) d1 (
      .clk(clk), .reset(reset),
      .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
      .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
      .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data), .in_last(in_last),
      .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]),
      .busy(bz[1]), .err_len(er[1]));

   fc_stream_engine #(.DATA_W(16), .ACC_W(40), .IN_LEN(4), .OUT_LEN(2), .FRAC_BITS(8), .RELU_EN(0)) d2 (
      .clk(clk), .reset(reset),
      .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
      .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
      .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data), .in_last(in_last),
      .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2]),
      .busy(bz[2]), .err_len(er[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_w(input logic [2:0] addr, input logic [15:0] data);
      w_wr_en   = 1'b1;
      w_wr_addr = addr;
      w_wr_data = data;
      tick();
      w_wr_en   = 1'b0;
   endtask

   task automatic wr_b(input logic [0:0] addr, input logic [15:0] data);
      b_wr_en   = 1'b1;
      b_wr_addr = addr;
      b_wr_data = data;
      tick();
      b_wr_en   = 1'b0;
   endtask

   // w[j][0]=1, w[j][1]=2, b={5,-3}
   task automatic load_case1();
      for (int j = 0; j < 4; j++) begin
         wr_w(3'(2*j), 16'd1);
         wr_w(3'(2*j+1), 16'd2);
      end
      wr_b(1'b0, 16'd5);
      wr_b(1'b1, 16'hFFFD);
   endtask

   task automatic load_all(input logic [15:0] wval);
      for (int a = 0; a < 8; a++) begin
         wr_w(3'(a), wval);
      end
      wr_b(1'b0, 16'd0);
      wr_b(1'b1, 16'd0);
   endtask

   // Returns #1 after the accepting edge.
   task automatic send(input logic [15:0] x, input logic last);
      int n;
      in_data  = x;
      in_last  = last;
      in_valid = 1'b1;
      n = 0;
      while (!rdy[0] && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("in_ready_wait", 32'(rdy[0]), 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_case1();
      send(16'd1, 1'b0);
      send(16'd2, 1'b0);
      send(16'd3, 1'b0);
      send(16'd4, 1'b1);
   endtask

   // Waits for a result, checks all three instances, then accepts it.
   task automatic recv(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [15:0] e2, input logic elast);
      int n;
      out_ready = 1'b1;
      n = 0;
      while (!ov[0] && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(ov[0]), 32'd1);
      chk({tag, "_d0"}, 32'(od[0]), 32'(e0));
      chk({tag, "_d1"}, 32'(od[1]), 32'(e1));
      chk({tag, "_d2"}, 32'(od[2]), 32'(e2));
      chk({tag, "_last"}, 32'(ol[0]), 32'(elast));
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; w_wr_en = 1'b0; w_wr_addr = 3'd0; w_wr_data = 16'd0;
      b_wr_en = 1'b0; b_wr_addr = 1'b0; b_wr_data = 16'd0;
      in_valid = 1'b0; in_data = 16'd0; in_last = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 32'(rdy[0]), 32'd0);
      chk("rst_out_valid", 32'(ov[0]), 32'd0);
      chk("rst_out_last", 32'(ol[0]), 32'd0);
      chk("rst_busy", 32'(bz[0]), 32'd0);
      chk("rst_err", 32'(er[0]), 32'd0);
      reset = 1'b0;
      tick();
      chk("idle_in_ready", 32'(rdy[0]), 32'd1);

      // Case 1: y0 = 5 + 10 = 15, y1 = -3 + 20 = 17.
      // d2 sees (b<<8 + S) >>> 8 = b + floor(S/256): 5 and -3.
      load_case1();
      send_case1();
      chk("c1_latency", 32'(ov[0]), 32'd1);
      chk("c1_in_ready", 32'(rdy[0]), 32'd0);
      chk("c1_busy", 32'(bz[0]), 32'd1);
      chk("c1_err", 32'(er[0]), 32'd0);
      recv("c1_y0", 16'd15, 16'd15, 16'd5, 1'b0);
      recv("c1_y1", 16'd17, 16'd17, 16'hFFFD, 1'b1);
      chk("c1_done_valid", 32'(ov[0]), 32'd0);
      chk("c1_done_ready", 32'(rdy[0]), 32'd1);
      chk("c1_done_busy", 32'(bz[0]), 32'd0);

      // Case 3: backpressure holds y0 while a weight write is attempted.
      send_case1();
      for (int i = 0; i < 5; i++) begin
         w_wr_en   = 1'b1;
         w_wr_addr = 3'd0;
         w_wr_data = 16'd7;
         tick();
         chk("bp_valid", 32'(ov[0]), 32'd1);
         chk("bp_data", 32'(od[0]), 32'd15);
         chk("bp_last", 32'(ol[0]), 32'd0);
         chk("bp_in_ready", 32'(rdy[0]), 32'd0);
      end
      w_wr_en = 1'b0;
      recv("bp_y0", 16'd15, 16'd15, 16'd5, 1'b0);
      recv("bp_y1", 16'd17, 16'd17, 16'hFFFD, 1'b1);

      // Element IN_LEN-1 without in_last: error pulse, frame still ends.
      // y0 staying 15 also shows the blocked write to w[0][0] left it at 1.
      send(16'd1, 1'b0);
      send(16'd2, 1'b0);
      send(16'd3, 1'b0);
      send(16'd4, 1'b0);
      chk("long_err", 32'(er[0]), 32'd1);
      chk("long_valid", 32'(ov[0]), 32'd1);
      tick();
      chk("long_err_clr", 32'(er[0]), 32'd0);
      recv("long_y0", 16'd15, 16'd15, 16'd5, 1'b0);
      recv("long_y1", 16'd17, 16'd17, 16'hFFFD, 1'b1);

      // Case 4: early last after x=3,4. y0 = 5+7 = 12, y1 = -3+14 = 11.
      send(16'd3, 1'b0);
      send(16'd4, 1'b1);
      chk("c4_err", 32'(er[0]), 32'd1);
      chk("c4_valid", 32'(ov[0]), 32'd1);
      tick();
      chk("c4_err_clr", 32'(er[0]), 32'd0);
      recv("c4_y0", 16'd12, 16'd12, 16'd5, 1'b0);
      recv("c4_y1", 16'd11, 16'd11, 16'hFFFD, 1'b1);

      // Case 5: reset mid-frame, then a clean frame starting from the bias.
      send(16'd1, 1'b0);
      send(16'd2, 1'b0);
      reset = 1'b1;
      tick();
      chk("c5_rst_busy", 32'(bz[0]), 32'd0);
      chk("c5_rst_valid", 32'(ov[0]), 32'd0);
      chk("c5_rst_in_ready", 32'(rdy[0]), 32'd0);
      reset = 1'b0;
      tick();
      send_case1();
      chk("c5_err", 32'(er[0]), 32'd0);
      chk("c5_latency", 32'(ov[0]), 32'd1);
      recv("c5_y0", 16'd15, 16'd15, 16'd5, 1'b0);
      recv("c5_y1", 16'd17, 16'd17, 16'hFFFD, 1'b1);

      // Case 2: saturation. 4 * 0x7FFF^2 clips to 0x7FFF at every FRAC_BITS.
      load_all(16'h7FFF);
      send(16'h7FFF, 1'b0);
      send(16'h7FFF, 1'b0);
      send(16'h7FFF, 1'b0);
      send(16'h7FFF, 1'b1);
      recv("sat_pos_y0", 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
      recv("sat_pos_y1", 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
      // w = -32767: large negative -> 0x8000, or 0 with ReLU.
      load_all(16'h8001);
      send(16'h7FFF, 1'b0);
      send(16'h7FFF, 1'b0);
      send(16'h7FFF, 1'b0);
      send(16'h7FFF, 1'b1);
      recv("sat_neg_y0", 16'h8000, 16'h0000, 16'h8000, 1'b0);
      recv("sat_neg_y1", 16'h8000, 16'h0000, 16'h8000, 1'b1);

      // Case 6: Q8 path. 0x80*0x80 = 16384: d2 gives 0x40, d0/d1 give 0x4000.
      load_all(16'h0080);
      send(16'h0080, 1'b0);
      send(16'h0000, 1'b0);
      send(16'h0000, 1'b0);
      send(16'h0000, 1'b1);
      recv("q8_y0", 16'h4000, 16'h4000, 16'h0040, 1'b0);
      recv("q8_y1", 16'h4000, 16'h4000, 16'h0040, 1'b1);
      // x = -1: product -128. floor(-128/256) = -1 on d2; -128 on d0; 0 on d1.
      send(16'hFFFF, 1'b0);
      send(16'h0000, 1'b0);
      send(16'h0000, 1'b0);
      send(16'h0000, 1'b1);
      recv("q8_neg_y0", 16'hFF80, 16'h0000, 16'hFFFF, 1'b0);
      recv("q8_neg_y1", 16'hFF80, 16'h0000, 16'hFFFF, 1'b1);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
